// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Operands are latched at issue, and the result is committed to {hi,lo} on the last busy edge.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) > 0 ? $clog2(MAXC) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;

    logic               is_div, sdiv, smul, neg_a, neg_b;
    logic [2*WIDTH-1:0] ma, mb, prod, acc, res_d;
    logic [WIDTH-1:0]   ua, ub, q, r;

    assign is_div = op_q[2:1] == 2'b01;
    assign sdiv   = op_q == 3'd2;
    assign smul   = op_q != 3'd1;
    assign ma     = {{WIDTH{smul & a_q[WIDTH-1]}}, a_q};
    assign mb     = {{WIDTH{smul & b_q[WIDTH-1]}}, b_q};
    assign prod   = ma * mb;
    assign acc    = {hi_q, lo_q};
    // Signed divide works on magnitudes; MIN/-1 falls out as MIN with remainder 0.
    assign neg_a  = sdiv & a_q[WIDTH-1];
    assign neg_b  = sdiv & b_q[WIDTH-1];
    assign ua     = neg_a ? -a_q : a_q;
    assign ub     = neg_b ? -b_q : b_q;
    assign q      = ua / ub;
    assign r      = ua % ub;

    always_comb begin
        res_d = !is_div ? (op_q == 3'd6 ? acc + prod : op_q == 3'd7 ? acc - prod : prod)
              : b_q == '0 ? {a_q, {WIDTH{1'b1}}}
              : {neg_a ? -r : r, (neg_a ^ neg_b) ? -q : q};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (state_q == IDLE) begin
            if (start && !cancel) begin
                if (op == 3'd4) hi_q <= A;
                else if (op == 3'd5) lo_q <= A;
                else begin
                    state_q <= BUSY;
                    op_q    <= op;
                    a_q     <= A;
                    b_q     <= B;
                    cnt_q   <= op[2:1] == 2'b01 ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
                end
            end
        end else if (cancel) begin
            state_q <= IDLE;
        end else if (cnt_q == '0) begin
            {hi_q, lo_q} <= res_d;
            state_q      <= IDLE;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign busy = state_q == BUSY;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed bench for muldiv_unit with a scoreboard of expected {hi,lo}.
// A second instance covers the narrow single-cycle configuration.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, cancel = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] hi, lo;

    logic        start2 = 1'b0;
    logic [2:0]  op2 = 3'd0;
    logic [15:0] A2 = '0, B2 = '0;
    logic        busy2;
    logic [15:0] hi2, lo2;

    int n_assert = 0, n_fail = 0;
    logic [63:0] sb[$];

    muldiv_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .op(op2), .A(A2), .B(B2),
        .cancel(1'b0), .busy(busy2), .hi(hi2), .lo(lo2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, optionally re-start (MULT) or cancel at a given busy cycle, then score.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int n, input int inj_s, input int inj_c);
        int cnt = 0;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        while (busy && cnt < 50) begin
            cnt++;
            start  = (cnt == inj_s);
            if (start) begin op = 3'd0; A = 32'd5; B = 32'd5; end
            cancel = (cnt == inj_c);
            @(negedge clk);
        end
        start = 1'b0; cancel = 1'b0;
        chk({tag, ".cycles"}, 64'(cnt), 64'(n));
        chk({tag, ".hilo"}, {hi, lo}, sb.pop_front());
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; op = o; A = a;
        @(negedge clk);
        start = 1'b0;
        chk("mt.busy", 64'(busy), 64'(0));
    endtask

    initial begin
        logic [31:0] ra, rb;
        longint      sa, sb_;
        repeat (2) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.hi", 64'(hi), 64'(0));
        chk("rst.lo", 64'(lo), 64'(0));
        reset_n = 1'b1;

        run("mult_neg", 3'd0, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, 5, 0, 0);
        run("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 10, 0, 0);
        run("divu_zero", 3'd3, 32'd7, 32'd0, {32'd7, 32'hFFFFFFFF}, 10, 0, 0);
        run("div_min", 3'd2, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 10, 0, 0);
        run("div_negb", 3'd2, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 10, 0, 0);
        run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 5, 0, 0);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            sa = longint'($signed(ra)); sb_ = longint'($signed(rb));
            run("mult_rand", 3'd0, ra, rb, 64'(sa * sb_), 5, 0, 0);
            rb = $urandom_range(1, 5000);
            run("divu_rand", 3'd3, ra, rb, {ra % rb, ra / rb}, 10, 0, 0);
        end

        mt(3'd4, 32'h12345678);
        chk("mthi.hi", 64'(hi), 64'h12345678);
        mt(3'd5, 32'h0);
        chk("mtlo.lo", 64'(lo), 64'h0);
        chk("mtlo.hi", 64'(hi), 64'h12345678);
        run("madd", 3'd6, 32'h00010000, 32'h00010000, {32'h12345679, 32'h0}, 5, 0, 0);
        run("msub", 3'd7, 32'h00010000, 32'h00010000, {32'h12345678, 32'h0}, 5, 0, 0);

        run("divu_ignore", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, 10, 3, 0);
        run("mult_cancel", 3'd0, 32'd3, 32'd4, {32'd2, 32'd14}, 2, 0, 2);

        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 3'd0; A = 32'd3; B = 32'd4;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("start_cancel.busy", 64'(busy), 64'(0));
        @(negedge clk);
        chk("start_cancel.busy2", 64'(busy), 64'(0));
        chk("start_cancel.hilo", {hi, lo}, {32'd2, 32'd14});

        op = 3'd4; A = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        chk("nostart.busy", 64'(busy), 64'(0));
        chk("nostart.hi", 64'(hi), 64'd2);

        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst.busy", 64'(busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.busy", 64'(busy), 64'(0));
        chk("async_rst.hi", 64'(hi), 64'(0));
        chk("async_rst.lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        @(negedge clk);
        start2 = 1'b1; op2 = 3'd1; A2 = 16'hFFFF; B2 = 16'hFFFF;
        @(negedge clk);
        start2 = 1'b0;
        chk("w16.busy", 64'(busy2), 64'(1));
        @(negedge clk);
        chk("w16.done", 64'(busy2), 64'(0));
        chk("w16.hi", 64'(hi2), 64'hFFFE);
        chk("w16.lo", 64'(lo2), 64'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
